// File: rtl/bit4_signed_divider_if.sv
// Operand/result bundle for the sequential signed divider.
// The master side issues requests and the slave side returns results.
interface bit4_signed_divider_if #(
  parameter int N = 4
);
  logic                start;
  logic signed [N-1:0] dividend;
  logic signed [N-1:0] divisor;
  logic                busy;
  logic                done;
  logic signed [N:0]   quotient;
  logic signed [N-1:0] remainder;
  logic                div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/bit4_signed_divider.sv
// Sequential signed divider that truncates toward zero.
// It runs restoring division on the operand magnitudes and then applies the signs.
module bit4_signed_divider #(
  parameter int N = 4
) (
  input logic                  clk,
  input logic                  rst,
  bit4_signed_divider_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIV,
    SIGN
  } state_t;

  state_t          state_reg, state_next;

  logic [N-1:0]    dividend_reg;
  logic [N-1:0]    divisor_reg;
  logic [N-1:0]    dvs_mag_reg;
  logic [N-1:0]    rem_reg;
  logic [N-1:0]    quo_reg;
  logic [CW-1:0]   count_reg;
  logic            sign_q_reg;
  logic            sign_r_reg;
  logic            zero_div_reg;

  logic [N:0]      quotient_reg;
  logic [N-1:0]    remainder_reg;
  logic            done_reg;
  logic            dbz_reg;

  logic [N:0]      shifted;
  logic [N:0]      trial;
  logic [N-1:0]    rem_next;
  logic [N-1:0]    quo_next;

  // Unsigned magnitude: the most negative value maps onto 2^(N-1), which still fits.
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
    magnitude = v[N-1] ? (~v + N'(1)) : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = LOAD;
      LOAD:    state_next = DIV;
      DIV:     if (count_reg == CW'(N - 1)) state_next = SIGN;
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One restoring step. The remainder is always below the divisor, so the shifted
  // value fits in N bits. The extra top bit of the trial difference is its sign.
  always_comb begin
    shifted = {rem_reg, quo_reg[N-1]};
    trial   = shifted - {1'b0, dvs_mag_reg};
    if (!trial[N]) begin
      rem_next = trial[N-1:0];
      quo_next = {quo_reg[N-2:0], 1'b1};
    end else begin
      rem_next = shifted[N-1:0];
      quo_next = {quo_reg[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      dvs_mag_reg   <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      count_reg     <= '0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      zero_div_reg  <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            dividend_reg <= bus.dividend;
            divisor_reg  <= bus.divisor;
          end
        end
        LOAD: begin
          quo_reg      <= magnitude(dividend_reg);
          dvs_mag_reg  <= magnitude(divisor_reg);
          rem_reg      <= '0;
          count_reg    <= '0;
          sign_q_reg   <= dividend_reg[N-1] ^ divisor_reg[N-1];
          sign_r_reg   <= dividend_reg[N-1];
          zero_div_reg <= (divisor_reg == '0);
        end
        DIV: begin
          rem_reg   <= rem_next;
          quo_reg   <= quo_next;
          count_reg <= count_reg + CW'(1);
        end
        SIGN: begin
          done_reg <= 1'b1;
          dbz_reg  <= zero_div_reg;
          if (zero_div_reg) begin
            quotient_reg  <= '0;
            remainder_reg <= dividend_reg;
          end else begin
            quotient_reg  <= sign_q_reg ? (~{1'b0, quo_reg} + (N+1)'(1)) : {1'b0, quo_reg};
            remainder_reg <= sign_r_reg ? (~rem_reg + N'(1)) : rem_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_reg != IDLE);
  assign bus.done        = done_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_bit4_signed_divider.sv
// Self-checking bench for bit4_signed_divider. It runs directed scenarios and then
// an all-pairs sweep with random start spacing against a plain integer model.
module tb_bit4_signed_divider;
  localparam int N   = 4;
  localparam int LAT = N + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  bit4_signed_divider_if #(.N(N)) bus ();

  bit4_signed_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Integer semantics: division truncates toward zero and the remainder takes the dividend's sign.
  function automatic void model(input int a, input int b, output int q, output int r, output bit z);
    if (b == 0) begin
      q = 0; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Call this just after a falling edge. It returns at the falling edge of the done cycle.
  task automatic run_op(input int a, input int b, output int lat, output bit busy_ok);
    bus.start    = 1'b1;
    bus.dividend = N'(a);
    bus.divisor  = N'(b);
    lat     = -1;
    busy_ok = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        bus.start    = 1'b0;
        bus.dividend = N'($urandom);
        bus.divisor  = N'($urandom);
      end
      if (bus.done === 1'b1) begin
        lat = cyc;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    $display("op %0d / %0d : q=%0d r=%0d dbz=%0b lat=%0d", a, b, bus.quotient, bus.remainder,
             bus.div_by_zero, lat);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== '0) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b dbz=%b q=%b r=%b expected all zero",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_directed();
    int ta[8] = '{7, -7, 7, -8, -8, 5, 6, 0};
    int tb[8] = '{2, 2, -2, -1, 1, 0, 3, -3};
    int tq[8] = '{3, -3, -3, 8, -8, 0, 2, 0};
    int tr[8] = '{1, -1, 1, 0, 0, 5, 0, 0};
    bit tz[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    int lat;
    bit busy_ok;
    logic signed [N:0]   eq;
    logic signed [N-1:0] er;
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], lat, busy_ok);
      eq = (N+1)'(tq[i]);
      er = N'(tr[i]);
      checks++;
      if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== tz[i]) begin
        fails++;
        $display("FAIL directed_result %0d/%0d: got q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=%b",
                 ta[i], tb[i], bus.quotient, bus.remainder, bus.div_by_zero, eq, er, tz[i]);
      end
      checks++;
      if (lat != LAT || !busy_ok) begin
        fails++;
        $display("FAIL directed_timing %0d/%0d: got lat=%0d busy_ok=%b expected lat=%0d busy_ok=1",
                 ta[i], tb[i], lat, busy_ok, LAT);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
        fails++;
        $display("FAIL directed_pulse: got done=%b one cycle after done, expected 0", bus.done);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    bus.start = 1'b1; bus.dividend = N'(7); bus.divisor = N'(2);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == 2);
      if (cyc == 2) begin
        bus.dividend = N'(-8); bus.divisor = N'(3);
      end
      if (bus.done === 1'b1) begin
        lat = cyc;
        break;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (bus.quotient !== 5'sd3 || bus.remainder !== 4'sd1 || lat != LAT) begin
      fails++;
      $display("FAIL ignore_start_result: got q=%0d r=%0d lat=%0d expected q=3 r=1 lat=%0d",
               bus.quotient, bus.remainder, lat, LAT);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 5'sd3) begin
      fails++;
      $display("FAIL ignore_start_noqueue: got busy=%b done=%b q=%0d expected 0 0 3",
               bus.busy, bus.done, bus.quotient);
    end
  endtask

  task automatic test_back_to_back();
    int ta[3] = '{7, -8, -8};
    int tb[3] = '{-2, -1, 1};
    int tq[3] = '{-3, 8, -8};
    int tr[3] = '{1, 0, 0};
    int lat;
    bit busy_ok;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], lat, busy_ok);
      checks++;
      if (bus.quotient !== (N+1)'(tq[i]) || bus.remainder !== N'(tr[i]) || lat != LAT || !busy_ok) begin
        fails++;
        $display("FAIL back_to_back %0d/%0d: got q=%0d r=%0d lat=%0d busy_ok=%b expected q=%0d r=%0d lat=%0d",
                 ta[i], tb[i], bus.quotient, bus.remainder, lat, busy_ok, tq[i], tr[i], LAT);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    bit busy_ok;
    bit saw_done = 1'b0;
    bus.start = 1'b1; bus.dividend = N'(-7); bus.divisor = N'(2);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== '0) begin
      fails++;
      $display("FAIL reset_mid_op_clear: got busy=%b done=%b dbz=%b q=%b r=%b expected all zero",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      fails++;
      $display("FAIL reset_mid_op_abort: got done/busy activity after reset, expected none");
    end
    run_op(3, 3, lat, busy_ok);
    checks++;
    if (bus.quotient !== 5'sd1 || bus.remainder !== 4'sd0 || lat != LAT || !busy_ok) begin
      fails++;
      $display("FAIL reset_mid_op_recover: got q=%0d r=%0d lat=%0d expected q=1 r=0 lat=%0d",
               bus.quotient, bus.remainder, lat, LAT);
    end
  endtask

  task automatic test_sweep();
    int lat, gap, q, r;
    bit z, busy_ok;
    for (int a = -(1 << (N - 1)); a < (1 << (N - 1)); a++) begin
      for (int b = -(1 << (N - 1)); b < (1 << (N - 1)); b++) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          if (g == 0) begin
            checks++;
            if (bus.done !== 1'b0) begin
              fails++;
              $display("FAIL sweep_pulse: got done=%b after done cycle, expected 0", bus.done);
            end
          end
        end
        model(a, b, q, r, z);
        run_op(a, b, lat, busy_ok);
        checks++;
        if (bus.quotient !== (N+1)'(q)) begin
          fails++;
          $display("FAIL sweep_q %0d/%0d: got %0d expected %0d", a, b, bus.quotient, q);
        end
        checks++;
        if (bus.remainder !== N'(r)) begin
          fails++;
          $display("FAIL sweep_r %0d/%0d: got %0d expected %0d", a, b, bus.remainder, r);
        end
        checks++;
        if (bus.div_by_zero !== z) begin
          fails++;
          $display("FAIL sweep_dbz %0d/%0d: got %b expected %b", a, b, bus.div_by_zero, z);
        end
        checks++;
        if (lat != LAT) begin
          fails++;
          $display("FAIL sweep_latency %0d/%0d: got %0d expected %0d", a, b, lat, LAT);
        end
        checks++;
        if (!busy_ok) begin
          fails++;
          $display("FAIL sweep_busy %0d/%0d: got bad busy profile expected busy=1 until done", a, b);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
